// File: rtl/job_fifo_buffer_if.sv
// Job FIFO bus: writer/reader handshake and head/flag outputs.
// FIFO_ERR_FLAGS_EN adds the sticky err_ovf / err_udf flags.
interface job_fifo_buffer_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int CNT_WIDTH   = 6,
    parameter int SPACE_WIDTH = 4
);
    logic                   wr;
    logic [DATA_WIDTH-1:0]  w_data_d;
    logic [CNT_WIDTH-1:0]   w_data_c;
    logic                   rd;
    logic [DATA_WIDTH-1:0]  r_data_d;
    logic [CNT_WIDTH-1:0]   r_data_c;
    logic                   empty;
    logic                   full;
    logic [SPACE_WIDTH-1:0] space;
`ifdef FIFO_ERR_FLAGS_EN
    logic                   err_ovf;
    logic                   err_udf;
`endif

    modport master (
        output wr, w_data_d, w_data_c, rd,
        input  r_data_d, r_data_c, empty, full, space
`ifdef FIFO_ERR_FLAGS_EN
        , input err_ovf, err_udf
`endif
    );

    modport slave (
        input  wr, w_data_d, w_data_c, rd,
        output r_data_d, r_data_c, empty, full, space
`ifdef FIFO_ERR_FLAGS_EN
        , output err_ovf, err_udf
`endif
    );
endinterface

// File: rtl/job_fifo_buffer.sv
// First-word-fall-through FIFO of IPG job words {data, bit count}.
// FIFO_ERR_FLAGS_EN enables sticky overflow/underflow flags.
module job_fifo_buffer #(
    parameter int DATA_WIDTH  = 64,
    parameter int CNT_WIDTH   = 6,
    parameter int ADDR_WIDTH  = 3,
    parameter int SPACE_WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    job_fifo_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int WORD_WIDTH = DATA_WIDTH + CNT_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   OCC_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   OCC_MAX = DEPTH[ADDR_WIDTH:0];

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   occ;
    logic [WORD_WIDTH-1:0] head;
    logic                  empty;
    logic                  full;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = (occ == '0);
    assign full  = (occ == OCC_MAX);

    // A pop frees the slot a simultaneous push needs when full.
    assign wr_ok = bus.wr && (!full || bus.rd);
    assign rd_ok = bus.rd && !empty;

    assign head = mem[rd_ptr];

    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.space    = SPACE_WIDTH'(OCC_MAX - occ);
    assign bus.r_data_d = empty ? '0 : head[WORD_WIDTH-1:CNT_WIDTH];
    assign bus.r_data_c = empty ? '0 : head[CNT_WIDTH-1:0];

    // Storage array: written on accepted push, never cleared.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= {bus.w_data_d, bus.w_data_c};
        end
    end

    // Pointer advance, wrapping naturally modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy tracks push minus pop; both together leave it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags: dropped push and pop of an empty FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.err_ovf <= 1'b0;
            bus.err_udf <= 1'b0;
        end else begin
            if (bus.wr && full && !bus.rd) bus.err_ovf <= 1'b1;
            if (bus.rd && empty)           bus.err_udf <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_job_fifo_buffer.sv
// Self-checking bench for job_fifo_buffer against a queue model.
// Directed test-plan sequences followed by random traffic.
module tb_job_fifo_buffer;
    logic clk;
    logic reset;

    job_fifo_buffer_if bus ();

    job_fifo_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [69:0] model_q[$];
    bit          model_ovf;
    bit          model_udf;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [63:0] exp_d;
        logic [63:0] exp_c;
        int n;
        n = model_q.size();
        exp_d = (n > 0) ? model_q[0][69:6] : 64'd0;
        exp_c = (n > 0) ? 64'(model_q[0][5:0]) : 64'd0;
        check("empty", 64'(bus.empty), 64'(n == 0));
        check("full", 64'(bus.full), 64'(n == 8));
        check("space", 64'(bus.space), 64'(8 - n));
        check("r_data_d", bus.r_data_d, exp_d);
        check("r_data_c", 64'(bus.r_data_c), exp_c);
`ifdef FIFO_ERR_FLAGS_EN
        check("err_ovf", 64'(bus.err_ovf), 64'(model_ovf));
        check("err_udf", 64'(bus.err_udf), 64'(model_udf));
`endif
    endtask

    // One clock: apply the FIFO rules to the model, then compare.
    task automatic tick();
        bit w_ok;
        bit r_ok;
        int n;
        @(posedge clk);
        n = model_q.size();
        if (bus.wr && n == 8 && !bus.rd) model_ovf = 1'b1;
        if (bus.rd && n == 0) model_udf = 1'b1;
        w_ok = bus.wr && (n < 8 || bus.rd);
        r_ok = bus.rd && n > 0;
        if (r_ok) void'(model_q.pop_front());
        if (w_ok) model_q.push_back({bus.w_data_d, bus.w_data_c});
        #1;
        check_all();
    endtask

    task automatic drive(input bit w, input bit r,
                         input logic [63:0] d, input logic [5:0] c);
        bus.wr = w;
        bus.rd = r;
        bus.w_data_d = d;
        bus.w_data_c = c;
        tick();
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic drain();
        while (model_q.size() > 0) drive(1'b0, 1'b1, 64'd0, 6'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_ovf = 1'b0;
        model_udf = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.w_data_d = '0;
        bus.w_data_c = '0;
        reset = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Single word then pop.
        drive(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd40);
        check("single_c", 64'(bus.r_data_c), 64'd40);
        drive(1'b0, 1'b1, 64'd0, 6'd0);

        // Fill to full, drop a 9th write, read all back.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 64'(i), 6'(i + 1));
        check("fill_full", 64'(bus.full), 64'd1);
        drive(1'b1, 1'b0, 64'd99, 6'd9);
        for (int i = 0; i < 8; i++) begin
            check("fill_order", bus.r_data_d, 64'(i));
            drive(1'b0, 1'b1, 64'd0, 6'd0);
        end
        check("fill_empty", 64'(bus.empty), 64'd1);

        // Simultaneous push/pop while full.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 64'(100 + i), 6'(i));
        drive(1'b1, 1'b1, 64'hAA, 6'd63);
        check("full_rw_head", bus.r_data_d, 64'd101);
        drain();

        // Wrap-around at constant occupancy 3.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'(200 + i), 6'(i));
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, {$urandom, $urandom}, 6'($urandom));
        end
        check("wrap_space", 64'(bus.space), 64'd5);
        drain();

        // Empty corners: pop on empty, then push+pop on empty.
        drive(1'b0, 1'b1, 64'd0, 6'd0);
        drive(1'b1, 1'b1, 64'h5555, 6'd17);
        check("empty_rw_c", 64'(bus.r_data_c), 64'd17);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom_range(0, 2) == 0),
                  {$urandom, $urandom}, 6'($urandom));
        end
        drain();

        // Asynchronous reset with 3 entries queued.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 64'(300 + i), 6'(i));
        #3;
        reset = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        model_udf = 1'b0;
        check_all();
        #2;
        reset = 1'b1;
        drive(1'b1, 1'b0, 64'h77, 6'd7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
